// File: rtl/arm_ctrl_pkg.sv
// Shared types for the pipeline control block: FSM state encoding and the
// bundle of stage-register control strobes.
package arm_ctrl_pkg;

   localparam int DEF_CNT_W = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic freeze_if;
      logic flush_if;
      logic bubble_id;
      logic freeze_all;
   } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high reset.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush/bubble generation for IF, ID and EXE registers, memory-wait
// timeout FSM and saturating performance counters.
module pipeline_stall_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detection,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_if,
   output logic             flush_if,
   output logic             bubble_id,
   output logic             freeze_all,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                WC_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0]   WC_LIMIT = WC_W'(MEM_TIMEOUT);

   ctrl_state_t     state;
   logic [WC_W-1:0] wait_cyc;
   stage_ctrl_t     ctrl;
   logic            mem_stall;
   logic            stall_inc;
   logic            wait_inc;
   logic            flush_inc;

   assign mem_stall = mem_req & ~mem_ready;

   // Priority: memory/timeout freeze, then branch flush, then hazard stall.
   // Reset masks everything so stage registers see no strobes while held.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         if (mem_stall || (state == TIMEOUT)) begin
            ctrl.freeze_all = 1'b1;
         end else if (branch_taken) begin
            ctrl.flush_if  = 1'b1;
            ctrl.bubble_id = 1'b1;
         end else if (hazard_detection) begin
            ctrl.freeze_if = 1'b1;
            ctrl.bubble_id = 1'b1;
         end
      end
   end

   assign freeze_if  = ctrl.freeze_if;
   assign flush_if   = ctrl.flush_if;
   assign bubble_id  = ctrl.bubble_id;
   assign freeze_all = ctrl.freeze_all;

   assign stall_inc = ctrl.freeze_if;
   assign flush_inc = ctrl.flush_if;
   assign wait_inc  = ctrl.freeze_all & (state != TIMEOUT);

   // wait_cyc counts stall cycles already spent on the current access; the
   // cycle that observes wait_cyc == MEM_TIMEOUT without ready is the fatal one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cyc    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_stall) begin
                  state    <= MEM_WAIT;
                  wait_cyc <= WC_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_req || mem_ready) begin
                  state    <= RUN;
                  wait_cyc <= '0;
               end else if (wait_cyc == WC_LIMIT) begin
                  state       <= TIMEOUT;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cyc <= wait_cyc + WC_W'(1);
               end
            end
            TIMEOUT: begin
               mem_timeout <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cyc <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wait_inc),
      .count (wait_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule
